// File: rtl/operand_stage.sv
// One-entry registered operand stage: selects ROM/RAM/immediate operands with
// writeback forwarding, and refreshes held operands from writeback while stalled.
module operand_stage #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] prog_value,
    input  logic [WIDTH-1:0] rdata_rom,
    input  logic [WIDTH-1:0] rdata1_ram,
    input  logic [WIDTH-1:0] rdata2_ram,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             err
);

    // Handshake: a transfer happens on a side only in a cycle where its valid
    // and ready are both high at the rising edge; valid never depends on ready.
    localparam logic [1:0] MODE_ROM_IMM = 2'b00;
    localparam logic [1:0] MODE_RAM_RAM = 2'b01;
    localparam logic [1:0] MODE_RAM_IMM = 2'b10;

    logic             accept;
    logic             legal;
    logic             drain;
    logic             stall;
    logic [WIDTH-1:0] fwd1;
    logic [WIDTH-1:0] fwd2;
    logic [WIDTH-1:0] next1;
    logic [WIDTH-1:0] next2;
    logic             next_ram1;
    logic             next_ram2;
    logic [AW-1:0]    tag1_addr;
    logic [AW-1:0]    tag2_addr;
    logic             tag1_ram;
    logic             tag2_ram;
    logic             refresh1;
    logic             refresh2;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign legal    = (mode != 2'b11);
    assign drain    = out_valid && out_ready;
    assign stall    = out_valid && !out_ready;

    // Register 0 is hard-wired, so a writeback to it is never forwarded.
    assign fwd1 = (wb_valid && (wb_addr == raddr1) && (raddr1 != '0)) ? wb_data : rdata1_ram;
    assign fwd2 = (wb_valid && (wb_addr == raddr2) && (raddr2 != '0)) ? wb_data : rdata2_ram;

    always_comb begin
        next1     = rdata_rom;
        next2     = prog_value;
        next_ram1 = 1'b0;
        next_ram2 = 1'b0;
        case (mode)
            MODE_ROM_IMM: begin
                next1 = rdata_rom;
                next2 = prog_value;
            end
            MODE_RAM_RAM: begin
                next1     = fwd1;
                next2     = fwd2;
                next_ram1 = 1'b1;
                next_ram2 = 1'b1;
            end
            MODE_RAM_IMM: begin
                next1     = fwd1;
                next2     = prog_value;
                next_ram1 = 1'b1;
            end
            default: begin
                next1 = rdata_rom;
                next2 = prog_value;
            end
        endcase
    end

    assign refresh1 = stall && wb_valid && tag1_ram && (tag1_addr != '0) && (wb_addr == tag1_addr);
    assign refresh2 = stall && wb_valid && tag2_ram && (tag2_addr != '0) && (wb_addr == tag2_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            err       <= 1'b0;
            tag1_addr <= '0;
            tag2_addr <= '0;
            tag1_ram  <= 1'b0;
            tag2_ram  <= 1'b0;
        end else begin
            if (accept && legal) begin
                out_valid <= 1'b1;
                out1      <= next1;
                out2      <= next2;
                tag1_addr <= raddr1;
                tag2_addr <= raddr2;
                tag1_ram  <= next_ram1;
                tag2_ram  <= next_ram2;
            end else begin
                if (drain) begin
                    out_valid <= 1'b0;
                end
                if (refresh1) begin
                    out1 <= wb_data;
                end
                if (refresh2) begin
                    out2 <= wb_data;
                end
            end
            // An illegal request is consumed but only leaves a sticky error.
            if (accept && !legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: operand select, forwarding, stall refresh,
// back-to-back flow, illegal mode and asynchronous reset.
module tb_operand_stage;

    localparam int WIDTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] prog_value;
    logic [WIDTH-1:0] rdata_rom;
    logic [WIDTH-1:0] rdata1_ram;
    logic [WIDTH-1:0] rdata2_ram;
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    raddr2;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic             err;

    int checks = 0;
    int errors = 0;

    operand_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .prog_value (prog_value),
        .rdata_rom  (rdata_rom),
        .rdata1_ram (rdata1_ram),
        .rdata2_ram (rdata2_ram),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out1       (out1),
        .out2       (out2),
        .err        (err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] m, input logic [7:0] rom, input logic [7:0] imm,
                             input logic [2:0] a1, input logic [2:0] a2,
                             input logic [7:0] d1, input logic [7:0] d2);
        in_valid   = 1'b1;
        mode       = m;
        rdata_rom  = rom;
        prog_value = imm;
        raddr1     = a1;
        raddr2     = a2;
        rdata1_ram = d1;
        rdata2_ram = d2;
    endtask

    task automatic drive_wb(input logic v, input logic [2:0] a, input logic [7:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        mode       = 2'b00;
        prog_value = '0;
        rdata_rom  = '0;
        rdata1_ram = '0;
        rdata2_ram = '0;
        raddr1     = '0;
        raddr2     = '0;
        drive_wb(1'b0, 3'd0, 8'h00);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);

        // a request held during reset must not be taken
        drive_req(2'b00, 8'h77, 8'h66, 3'd0, 3'd0, 8'h00, 8'h00);
        step();
        chk("no_accept_in_reset", out_valid, 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();

        // rom/imm accept
        drive_req(2'b00, 8'h12, 8'h34, 3'd0, 3'd0, 8'h00, 8'h00);
        chk("rom_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("rom_out_valid", out_valid, 1);
        chk("rom_out1", out1, 8'h12);
        chk("rom_out2", out2, 8'h34);
        step();
        chk("drain_out_valid", out_valid, 0);
        chk("drain_hold_out1", out1, 8'h12);
        chk("drain_hold_out2", out2, 8'h34);

        // ram/ram with forwarding on operand 2
        drive_req(2'b01, 8'h00, 8'h00, 3'd3, 3'd5, 8'h10, 8'h20);
        drive_wb(1'b1, 3'd5, 8'hAA);
        step();
        in_valid = 1'b0;
        drive_wb(1'b0, 3'd0, 8'h00);
        chk("fwd_out_valid", out_valid, 1);
        chk("fwd_out1", out1, 8'h10);
        chk("fwd_out2", out2, 8'hAA);
        step();

        // ram1/imm, then 3-cycle stall with writeback refresh in cycle 2
        drive_req(2'b10, 8'h00, 8'h77, 3'd4, 3'd4, 8'h40, 8'h41);
        step();
        chk("r1i_out1", out1, 8'h40);
        chk("r1i_out2", out2, 8'h77);
        out_ready = 1'b0;
        drive_req(2'b00, 8'hE1, 8'hE2, 3'd0, 3'd0, 8'h00, 8'h00);
        #1;
        chk("stall1_in_ready", in_ready, 0);
        step();
        chk("stall1_out1", out1, 8'h40);
        chk("stall1_out_valid", out_valid, 1);
        drive_wb(1'b1, 3'd4, 8'h5C);
        #1;
        chk("stall2_in_ready", in_ready, 0);
        step();
        chk("refresh_out1", out1, 8'h5C);
        chk("refresh_out2", out2, 8'h77);
        chk("stall2_out_valid", out_valid, 1);
        drive_wb(1'b1, 3'd6, 8'h99);
        #1;
        chk("stall3_in_ready", in_ready, 0);
        step();
        chk("stall3_out1", out1, 8'h5C);
        chk("stall3_out2", out2, 8'h77);
        chk("stall3_out_valid", out_valid, 1);
        drive_wb(1'b0, 3'd0, 8'h00);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("stall_release", out_valid, 0);

        // both ram tags refreshed by one writeback
        drive_req(2'b01, 8'h00, 8'h00, 3'd2, 3'd2, 8'h21, 8'h22);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_wb(1'b1, 3'd2, 8'h3C);
        step();
        drive_wb(1'b0, 3'd0, 8'h00);
        chk("both_refresh_out1", out1, 8'h3C);
        chk("both_refresh_out2", out2, 8'h3C);
        out_ready = 1'b1;
        step();

        // back-to-back immediates 1..4
        for (int k = 1; k <= 4; k++) begin
            drive_req(2'b00, 8'h50, k[7:0], 3'd0, 3'd0, 8'h00, 8'h00);
            step();
            chk("b2b_out_valid", out_valid, 1);
            chk("b2b_out2", out2, k);
        end
        in_valid = 1'b0;
        step();
        chk("b2b_drain", out_valid, 0);

        // illegal mode when idle
        drive_req(2'b11, 8'hEE, 8'hEE, 3'd1, 3'd1, 8'hEE, 8'hEE);
        step();
        in_valid = 1'b0;
        chk("ill_err", err, 1);
        chk("ill_out_valid", out_valid, 0);
        chk("ill_out1", out1, 8'h50);
        chk("ill_out2", out2, 8'h04);
        drive_req(2'b00, 8'h21, 8'h43, 3'd0, 3'd0, 8'h00, 8'h00);
        step();
        chk("post_ill_valid", out_valid, 1);
        chk("post_ill_out1", out1, 8'h21);
        chk("post_ill_out2", out2, 8'h43);
        chk("post_ill_err", err, 1);

        // illegal mode while draining: output empties, data unchanged
        drive_req(2'b11, 8'hEE, 8'hEE, 3'd1, 3'd1, 8'hEE, 8'hEE);
        #1;
        chk("ill_drain_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("ill_drain_valid", out_valid, 0);
        chk("ill_drain_out1", out1, 8'h21);
        chk("ill_drain_err", err, 1);

        // address 0 never forwarded, nor refreshed
        drive_req(2'b01, 8'h00, 8'h00, 3'd0, 3'd0, 8'h55, 8'h66);
        drive_wb(1'b1, 3'd0, 8'hFF);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("zero_out1", out1, 8'h55);
        chk("zero_out2", out2, 8'h66);
        step();
        chk("zero_norefresh_out1", out1, 8'h55);
        chk("zero_norefresh_out2", out2, 8'h66);
        drive_wb(1'b0, 3'd0, 8'h00);

        // asynchronous reset mid-stall
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out1", out1, 0);
        chk("arst_out2", out2, 0);
        chk("arst_err", err, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        drive_req(2'b00, 8'h09, 8'h0A, 3'd0, 3'd0, 8'h00, 8'h00);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_out1", out1, 8'h09);
        chk("post_rst_out2", out2, 8'h0A);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and data width in bits.
REQ-002 The block SHALL have parameter AW, default 3, giving the register address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the stage accepts a request this cycle.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 = rom/imm, 01 = ram/ram, 10 = ram1/imm, 11 = illegal.
REQ-008 The block SHALL have port prog_value, input, WIDTH bits: the immediate value.
REQ-009 The block SHALL have port rdata_rom, input, WIDTH bits: the ROM register read data.
REQ-010 The block SHALL have ports rdata1_ram and rdata2_ram, inputs, WIDTH bits each: the RAM register read data.
REQ-011 The block SHALL have ports raddr1 and raddr2, inputs, AW bits each: the RAM read addresses, used for forwarding.
REQ-012 The block SHALL have ports wb_valid (1 bit), wb_addr (AW bits) and wb_data (WIDTH bits), inputs: the writeback bus.
REQ-013 The block SHALL have port out_valid, output, 1 bit: the registered operands are valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the operands.
REQ-015 The block SHALL have ports out1 and out2, outputs, WIDTH bits each: the registered operands.
REQ-016 The block SHALL have port err, output, 1 bit: sticky flag, set when an illegal mode is seen.

Function
REQ-017 The block SHALL be a one-entry registered pipeline stage, with in_ready = !out_valid || out_ready (combinational).
REQ-018 Accept: on in_valid && in_ready and mode != 11, the block SHALL register out1/out2 and set out_valid = 1 on the next edge (latency 1 cycle).
REQ-019 Operand select on accept SHALL be:
- mode 00: out1 = rdata_rom, out2 = prog_value.
- mode 01: out1 = fwd1, out2 = fwd2.
- mode 10: out1 = fwd1, out2 = prog_value.
REQ-020 fwd1 SHALL equal wb_data when wb_valid && wb_addr == raddr1 && raddr1 != 0, else rdata1_ram; fwd2 SHALL be defined the same way using raddr2/rdata2_ram.
REQ-021 Address 0 SHALL never be forwarded.
REQ-022 On accept, the block SHALL also latch per-operand source tags: the RAM address and a "ram-sourced" bit for out1 and for out2.
REQ-023 Stall refresh: while out_valid && !out_ready, if wb_valid and wb_addr equals a latched ram-sourced tag (non-zero), the corresponding out register SHALL load wb_data; both operands update if both match.
REQ-024 Drain: on out_valid && out_ready with no accept in the same cycle, out_valid SHALL go to 0 on the next edge, and out1/out2 SHALL hold their values.
REQ-025 Simultaneous drain and accept SHALL load the new operands with out_valid staying 1, giving back-to-back throughput of 1 per cycle.
REQ-026 Illegal mode: on in_valid && in_ready && mode == 11, the request SHALL be consumed (in_ready behaves as normal), out_valid SHALL NOT be set by it, err SHALL be set to 1, and out1/out2 SHALL be unchanged.
REQ-027 err SHALL stay at 1 until reset.
REQ-028 While out_valid && !out_ready, out1/out2 SHALL change only through the stall refresh of REQ-023.
REQ-029 in_valid = 0 SHALL leave all state unchanged apart from drain (REQ-024) and refresh (REQ-023).

Reset
REQ-030 Asserting reset SHALL immediately (asynchronously) force out_valid = 0, out1 = 0, out2 = 0, err = 0 and all tags = 0, including when asserted mid-stall.
REQ-031 After reset, in_ready SHALL read 1.
REQ-032 The first accept after reset deassertion SHALL occur no earlier than the first clk rising edge with reset low.

Verification
REQ-033 WIDTH=8: mode 00, rdata_rom=0x12, prog_value=0x34, accept, out_ready=1 -> next cycle out_valid=1, out1=0x12, out2=0x34.
REQ-034 mode 01, raddr1=3, raddr2=5, rdata1_ram=0x10, rdata2_ram=0x20, with wb_valid=1, wb_addr=5, wb_data=0xAA in the same cycle -> out1=0x10, out2=0xAA.
REQ-035 Accept mode 10 with raddr1=4, then out_ready=0 for 3 cycles; wb 4<-0x5C in cycle 2 -> out1 becomes 0x5C, out2 unchanged, in_ready=0 throughout the stall, out_valid held at 1.
REQ-036 Back-to-back: in_valid=1 and out_ready=1 for 4 cycles with distinct immediates 1,2,3,4 -> out2 shows 1,2,3,4 on consecutive cycles with no bubble.
REQ-037 mode 11 accepted -> err=1 next cycle, out_valid=0; a following legal request proceeds normally and err stays at 1.
REQ-038 Forwarding to address 0: raddr1=0, wb_addr=0, wb_valid=1 -> out1 = rdata1_ram, not wb_data.
REQ-039 Asserting reset during a stall -> out_valid, out1, out2 and err read 0 before the next clk edge.
